// File: rtl/mips_debug_pkg.sv
// Shared definitions for the MIPS debug/run-control path: UART command bytes,
// run-control FSM encoding and the HALT opcode used by decode as well.
package mips_debug_pkg;

    localparam logic [7:0] CMD_LOAD    = 8'h4C;
    localparam logic [7:0] CMD_CONT    = 8'h43;
    localparam logic [7:0] CMD_STEP    = 8'h53;
    localparam logic [7:0] CMD_NEXT    = 8'h4E;
    localparam logic [7:0] CMD_RESTART = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_HALTED    = 3'd4
    } run_state_t;

    localparam int         OPCODE_MSB  = 31;
    localparam int         OPCODE_LSB  = 26;
    localparam logic [5:0] OPCODE_HALT = 6'b111111;

    function automatic logic is_halt_opcode(input logic [5:0] opcode);
        return opcode == OPCODE_HALT;
    endfunction

endpackage

// File: rtl/rx_word_assembler.sv
// Packs a stream of bytes into big-endian words; word_valid pulses for one
// cycle once the last byte of a word has been shifted in.
module rx_word_assembler #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            rx_byte,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int               BYTES     = DATA_WIDTH / 8;
    localparam int               CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0] byte_cnt;

    // The word keeps shifting while word_valid is high, so the first byte of
    // the next word can land in the same cycle as the write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                word <= {word[DATA_WIDTH-9:0], rx_byte};
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt   <= '0;
                    word_valid <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_run_control.sv
// Run-control sequencer: loads instruction memory from the UART stream, runs
// or single-steps the pipeline, and freezes when HALT reaches write-back.
module pipeline_run_control
    import mips_debug_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int CYCLE_CNT_WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_valid,
    input  logic                       i_halt_wb,
    output logic                       o_imem_wr_en,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_wr_addr,
    output logic [DATA_WIDTH-1:0]      o_imem_wr_data,
    output logic                       o_pipe_enable,
    output logic                       o_pipe_reset,
    output logic [CYCLE_CNT_WIDTH-1:0] o_cycle_count,
    output logic [2:0]                 o_state,
    output logic                       o_halted,
    output logic                       o_load_error
);

    run_state_t                 state, state_next;
    logic [IMEM_ADDR_WIDTH-1:0] addr, addr_next;
    logic [CYCLE_CNT_WIDTH-1:0] cycle_cnt, cycle_cnt_next;
    logic                       step_pulse, step_pulse_next;
    logic                       pipe_reset, pipe_reset_next;
    logic                       load_error, load_error_next;
    logic                       asm_clear, asm_feed;
    logic                       word_valid;
    logic [DATA_WIDTH-1:0]      word;
    logic                       pipe_enable, halt_taken;

    function automatic logic [CYCLE_CNT_WIDTH-1:0] sat_inc(input logic [CYCLE_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rx_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clear     (asm_clear),
        .byte_valid(asm_feed),
        .rx_byte   (i_rx_data),
        .word_valid(word_valid),
        .word      (word)
    );

    assign pipe_enable = (state == ST_RUN) || step_pulse;
    assign halt_taken  = pipe_enable && i_halt_wb;

    always_comb begin
        state_next      = state;
        addr_next       = addr;
        cycle_cnt_next  = cycle_cnt;
        step_pulse_next = 1'b0;
        pipe_reset_next = 1'b0;
        load_error_next = load_error;
        asm_clear       = 1'b0;
        asm_feed        = 1'b0;
        if (pipe_enable)
            cycle_cnt_next = sat_inc(cycle_cnt);
        unique case (state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_next      = ST_LOAD;
                            addr_next       = '0;
                            load_error_next = 1'b0;
                            asm_clear       = 1'b1;
                        end
                        CMD_CONT: state_next = ST_RUN;
                        CMD_STEP: state_next = ST_STEP_WAIT;
                        default:  ;
                    endcase
                end
            end
            ST_LOAD: begin
                asm_feed = i_rx_valid;
                if (word_valid) begin
                    // The address saturates at the last word instead of wrapping.
                    if (!(&addr))
                        addr_next = addr + 1'b1;
                    if (is_halt_opcode(word[OPCODE_MSB:OPCODE_LSB])) begin
                        state_next = ST_IDLE;
                    end else if (&addr) begin
                        load_error_next = 1'b1;
                        state_next      = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (halt_taken)
                    state_next = ST_HALTED;
            end
            ST_STEP_WAIT: begin
                // A halt in the stepped cycle wins and swallows any byte alongside it.
                if (halt_taken) begin
                    state_next = ST_HALTED;
                end else if (i_rx_valid) begin
                    if (i_rx_data == CMD_NEXT)
                        step_pulse_next = 1'b1;
                    else if (i_rx_data == CMD_CONT)
                        state_next = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (i_rx_valid && i_rx_data == CMD_RESTART) begin
                    state_next      = ST_IDLE;
                    pipe_reset_next = 1'b1;
                    cycle_cnt_next  = '0;
                    addr_next       = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            addr       <= '0;
            cycle_cnt  <= '0;
            step_pulse <= 1'b0;
            pipe_reset <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_next;
            addr       <= addr_next;
            cycle_cnt  <= cycle_cnt_next;
            step_pulse <= step_pulse_next;
            pipe_reset <= pipe_reset_next;
            load_error <= load_error_next;
        end
    end

    assign o_imem_wr_en   = word_valid;
    assign o_imem_wr_addr = addr;
    assign o_imem_wr_data = word;
    assign o_pipe_enable  = pipe_enable;
    assign o_pipe_reset   = pipe_reset;
    assign o_cycle_count  = cycle_cnt;
    assign o_state        = state;
    assign o_halted       = (state == ST_HALTED);
    assign o_load_error   = load_error;

endmodule

// File: tb/tb_pipeline_run_control.sv
// Bench for pipeline_run_control: random loads/runs/steps against a reference
// model, with a monitor scoring memory writes and pipeline-reset pulses.
module tb_pipeline_run_control;

    localparam int AW = 2;
    localparam int CW = 4;
    localparam int DW = 32;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          halt_wb = 1'b0;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [DW-1:0] imem_wr_data;
    logic          pipe_enable;
    logic          pipe_reset;
    logic [CW-1:0] cycle_count;
    logic [2:0]    dut_state;
    logic          halted;
    logic          load_error;

    pipeline_run_control #(
        .DATA_WIDTH(DW), .IMEM_ADDR_WIDTH(AW), .CYCLE_CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_halt_wb(halt_wb), .o_imem_wr_en(imem_wr_en), .o_imem_wr_addr(imem_wr_addr),
        .o_imem_wr_data(imem_wr_data), .o_pipe_enable(pipe_enable), .o_pipe_reset(pipe_reset),
        .o_cycle_count(cycle_count), .o_state(dut_state), .o_halted(halted),
        .o_load_error(load_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_rst = 0;
    int          en_cnt = 0;
    wr_t         wr_q[$];
    logic [31:0] prog[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scores every write strobe and pipeline-reset pulse as it appears.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (pipe_enable) en_cnt++;
            if (imem_wr_en) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                             imem_wr_addr, imem_wr_data);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", 64'(imem_wr_addr), 64'(e.addr));
                    check("wr_data", 64'(imem_wr_data), 64'(e.data));
                end
            end
            if (pipe_reset) begin
                n_checks++;
                if (exp_rst == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pipe_reset: got pulse, expected none");
                end else begin
                    exp_rst--;
                end
            end
        end
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    function automatic bit is_halt(input logic [31:0] w);
        return w[31:26] == 6'h3F;
    endfunction

    function automatic bit is_cmd(input logic [7:0] b);
        return b inside {8'h4C, 8'h43, 8'h53, 8'h4E, 8'h52};
    endfunction

    task automatic make_prog(input int halt_pct);
        logic [31:0] w;
        prog.delete();
        for (int i = 0; i < (1 << AW); i++) begin
            w = $urandom;
            if ($urandom_range(99) < halt_pct) w[31:26] = 6'h3F;
            else if (w[31:26] == 6'h3F) w[26] = 1'b0;
            prog.push_back(w);
            if (is_halt(w)) break;
        end
    endtask

    // Reference loader: word i goes to address i until a HALT word or the last address.
    task automatic run_load(input int gap_max);
        bit   err;
        logic [31:0] w;
        wr_t  e;
        err = 1'b1;
        for (int i = 0; i < prog.size(); i++) begin
            e.addr = AW'(i);
            e.data = prog[i];
            wr_q.push_back(e);
            if (is_halt(prog[i])) begin
                err = 1'b0;
                break;
            end
        end
        send(8'h4C);
        check("state_after_L", 64'(dut_state), 64'd1);
        check("load_error_cleared", 64'(load_error), 64'd0);
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            for (int b = 3; b >= 0; b--) begin
                send(w[b*8 +: 8]);
                if (!(i == prog.size() - 1 && b == 0)) tick($urandom_range(gap_max));
            end
        end
        tick(2);
        check("load_end_state", 64'(dut_state), 64'd0);
        check("load_error", 64'(load_error), 64'(err));
        check("writes_outstanding", 64'(wr_q.size()), 64'd0);
    endtask

    task automatic run_cont(input int n);
        int e0;
        int c0;
        c0 = int'(cycle_count);
        send(8'h43);
        check("run_state", 64'(dut_state), 64'd2);
        check("run_enable", 64'(pipe_enable), 64'd1);
        e0 = en_cnt;
        tick(n);
        halt_wb = 1'b1;
        tick(1);
        halt_wb = 1'b0;
        check("run_count", 64'(cycle_count), 64'((c0 + n + 1 > CNT_MAX) ? CNT_MAX : c0 + n + 1));
        check("run_halted", 64'(halted), 64'd1);
        check("run_enable_off", 64'(pipe_enable), 64'd0);
        check("run_enable_cycles", 64'(en_cnt - e0), 64'(n + 1));
        // Frozen while halted: halt strobes, 'C' and 'N' have no effect.
        c0 = int'(cycle_count);
        e0 = en_cnt;
        halt_wb = 1'($urandom);
        tick(2);
        halt_wb = 1'b0;
        send(8'h43);
        send(8'h4E);
        tick(2);
        check("halted_state_hold", 64'(dut_state), 64'd4);
        check("halted_count_frozen", 64'(cycle_count), 64'(c0));
        check("halted_no_enable", 64'(en_cnt - e0), 64'd0);
    endtask

    task automatic restart();
        exp_rst++;
        send(8'h52);
        check("restart_pulse", 64'(pipe_reset), 64'd1);
        check("restart_count", 64'(cycle_count), 64'd0);
        check("restart_halted", 64'(halted), 64'd0);
        check("restart_state", 64'(dut_state), 64'd0);
        tick(1);
        check("restart_pulse_width", 64'(pipe_reset), 64'd0);
        check("restart_outstanding", 64'(exp_rst), 64'd0);
    endtask

    task automatic run_step(input int k, input int gap_lo, input int gap_hi, input bit end_cont);
        int e0;
        int g;
        send(8'h53);
        check("step_state", 64'(dut_state), 64'd3);
        check("step_idle_enable", 64'(pipe_enable), 64'd0);
        e0 = en_cnt;
        for (int i = 0; i < k; i++) begin
            send(8'h4E);
            check("step_pulse_high", 64'(pipe_enable), 64'd1);
            tick(1);
            check("step_pulse_width", 64'(pipe_enable), 64'd0);
            g = $urandom_range(gap_hi, gap_lo);
            halt_wb = 1'($urandom);
            tick(g);
            halt_wb = 1'b0;
        end
        check("step_count", 64'(cycle_count), 64'(k));
        check("step_enable_cycles", 64'(en_cnt - e0), 64'(k));
        check("step_state_hold", 64'(dut_state), 64'd3);
        if (end_cont) begin
            send(8'h43);
            check("step_to_run_state", 64'(dut_state), 64'd2);
            for (int i = 0; i < 4; i++) begin
                check("step_to_run_enable", 64'(pipe_enable), 64'd1);
                tick(1);
            end
            halt_wb = 1'b1;
            tick(1);
            halt_wb = 1'b0;
            check("step_run_count", 64'(cycle_count), 64'((k + 5 > CNT_MAX) ? CNT_MAX : k + 5));
        end else begin
            send(8'h4E);
            halt_wb = 1'b1;
            send(8'h4E);
            halt_wb = 1'b0;
            tick(2);
            check("step_halt_count", 64'(cycle_count), 64'(k + 1));
            check("step_halt_no_extra", 64'(en_cnt - e0), 64'(k + 1));
        end
        check("step_halted_state", 64'(dut_state), 64'd4);
        check("step_halted_flag", 64'(halted), 64'd1);
    endtask

    initial begin
        logic [7:0] b;
        rst_n = 1'b0;
        tick(2);
        check("reset_state", 64'(dut_state), 64'd0);
        check("reset_wr_en", 64'(imem_wr_en), 64'd0);
        check("reset_wr_data", 64'(imem_wr_data), 64'd0);
        check("reset_enable", 64'(pipe_enable), 64'd0);
        check("reset_count", 64'(cycle_count), 64'd0);
        check("reset_halted", 64'(halted), 64'd0);
        check("reset_load_error", 64'(load_error), 64'd0);
        rst_n = 1'b1;
        tick(1);

        repeat (6) begin
            b = 8'($urandom);
            if (is_cmd(b)) b = 8'h00;
            send(b);
            check("idle_ignores_byte", 64'(dut_state), 64'd0);
        end

        prog.delete();
        prog.push_back(32'h20010005);
        prog.push_back(32'hFC000000);
        run_load(0);

        make_prog(0);
        run_load(1);
        repeat (4) send(8'h00);
        tick(2);
        check("overflow_idle", 64'(dut_state), 64'd0);
        check("overflow_error_sticky", 64'(load_error), 64'd1);

        repeat (6) begin
            make_prog(35);
            run_load(2);
        end

        send(8'h4C);
        send(8'h12);
        send(8'h34);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_state", 64'(dut_state), 64'd0);
        check("async_reset_error", 64'(load_error), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        prog.delete();
        prog.push_back(32'hFC00ABCD);
        run_load(0);

        run_cont(9);
        restart();
        run_cont($urandom_range(20, 12));
        restart();
        run_cont($urandom_range(8, 1));
        restart();

        run_step(3, 3, 3, 1'b1);
        restart();
        run_step($urandom_range(5, 1), 0, 3, 1'b0);
        restart();

        check("final_writes_outstanding", 64'(wr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_run_control.md
Name: pipeline_run_control

Overview:
- Top-level sequencer for the MIPS pipeline, driven by the UART debug byte stream.
- Loads the program into instruction memory word by word.
- Runs the pipeline either continuously or one clock at a time (step mode), and detects the HALT instruction reaching write-back.
- Counts executed cycles and freezes on HALT until the host issues a restart.

Parameters:
- DATA_WIDTH, 32, instruction/word width.
- IMEM_ADDR_WIDTH, 8, instruction memory word-address width (256 words).
- CYCLE_CNT_WIDTH, 32, width of the executed-cycle counter.

Ports:
- i_clk  input  1  system clock; all state changes on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rx_data  input  8  received UART byte.
- i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid.
- i_halt_wb  input  1  HALT instruction is in the write-back stage.
- o_imem_wr_en  output  1  instruction memory write strobe.
- o_imem_wr_addr  output  IMEM_ADDR_WIDTH  word write address.
- o_imem_wr_data  output  DATA_WIDTH  word to write.
- o_pipe_enable  output  1  pipeline clock-enable; all pipeline registers advance only when high.
- o_pipe_reset  output  1  one-cycle synchronous pipeline/PC clear request.
- o_cycle_count  output  CYCLE_CNT_WIDTH  number of enabled cycles since the last restart.
- o_state  output  3  current FSM state encoding.
- o_halted  output  1  program has reached HALT.
- o_load_error  output  1  sticky flag: memory filled without a HALT word.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - All outputs 0; address, byte counter and cycle counter cleared.
  - A partially assembled word is discarded.
- Command bytes: 'L'=0x4C, 'C'=0x43, 'S'=0x53, 'N'=0x4E, 'R'=0x52. Any other byte is ignored in every state.
- States: IDLE=0, LOAD=1, RUN=2, STEP_WAIT=3, HALTED=4.
- IDLE:
  - 'L' -> LOAD, clearing address, byte counter and o_load_error.
  - 'C' -> RUN.
  - 'S' -> STEP_WAIT.
- LOAD:
  - Every valid byte is data; the first byte goes to [31:24], big-endian.
  - On the 4th byte, o_imem_wr_en is high for exactly one cycle in the following cycle, with the assembled word and the current address; the address then increments.
  - If the written word has [31:26]==6'b111111 (HALT) -> IDLE after the write.
  - Else if the address written was 2^IMEM_ADDR_WIDTH-1 -> o_load_error=1, go to IDLE; the address does not wrap.
  - A byte arriving in the same cycle as the write pulse is still accepted as the first byte of the next word.
- RUN:
  - o_pipe_enable=1 every cycle spent in RUN.
  - o_cycle_count increments each enabled cycle and saturates at all-ones.
  - i_halt_wb=1 during an enabled cycle -> HALTED; o_pipe_enable is 0 from the next cycle.
  - Received bytes are ignored in RUN.
- STEP_WAIT:
  - o_pipe_enable=0 by default.
  - Each 'N' gives o_pipe_enable=1 for exactly one cycle, in the cycle after the byte strobe, and o_cycle_count+1.
  - If i_halt_wb=1 in that enabled cycle -> HALTED.
  - 'C' -> RUN.
- HALTED:
  - o_halted=1 and o_pipe_enable=0; the counter is frozen.
  - 'R' -> o_pipe_reset=1 for one cycle, cycle counter and write address cleared, o_halted=0, then IDLE.
- Simultaneous events:
  - i_halt_wb takes priority over a byte received in the same cycle; that byte is dropped.
  - i_halt_wb is ignored whenever o_pipe_enable=0.
- Latency: command byte to state change is 1 cycle; 4th data byte to write strobe is 1 cycle.

Decomposition:
- Shared package mips_debug_pkg holds:
  - command byte constants;
  - FSM state encoding (3 bits);
  - HALT opcode 6'b111111 and the opcode field position [31:26], which are also used by the decode control unit.
- One sub-module, rx_word_assembler:
  - byte counter plus shift register;
  - outputs a word-valid pulse and the assembled word;
  - clear input.
- The FSM, address counter and cycle counter stay in pipeline_run_control.

Test Plan:
- Load: after reset, send 'L' then 0x20,0x01,0x00,0x05, then 0xFC,0x00,0x00,0x00 -> two write pulses: addr 0 data 0x20010005, addr 1 data 0xFC000000; state returns to IDLE and o_load_error=0.
- Overflow: with IMEM_ADDR_WIDTH=2, send 'L' plus 4 non-HALT words -> writes at addr 0..3, o_load_error=1, state IDLE, no 5th write.
- Continuous run: send 'C', hold i_halt_wb=0 for 9 cycles then 1 -> o_cycle_count=10, o_halted=1, o_pipe_enable low from the next cycle.
- Step mode: send 'S' then three 'N' bytes spaced 5 cycles apart -> exactly three 1-cycle enable pulses and o_cycle_count=3. Then 'C' -> continuous enable.
- Restart: from HALTED send 'R' -> one-cycle o_pipe_reset, count=0, o_halted=0, state IDLE. Also send 'N' in the same cycle as i_halt_wb during stepping -> the halt wins and no extra pulse is produced.
- Async reset: assert i_rst_n=0 after 2 bytes of a word in LOAD, then resume with 4 bytes after 'L' -> a single write at addr 0 containing only the new 4 bytes.
